// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
// Shared definitions for the second-generation SPI slave:
//   - FSM state encodings (kept as plain 3-bit constants so older tools
//     and waveform scripts that expect numeric states still work)
//   - command field encodings carried in rx_data[DATA_W+1:DATA_W]
//   - cnt_width(): width of the bit counter for a given data width
package spi_slave_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t CHK_CMD   = 3'd1;
  localparam state_t WRITE     = 3'd2;
  localparam state_t READ_ADD  = 3'd3;
  localparam state_t READ_DATA = 3'd4;
  localparam state_t READ_WAIT = 3'd5;
  localparam state_t READ_TX   = 3'd6;
  localparam state_t DONE      = 3'd7;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  // The counter must hold DATA_W+2 (a full rx frame), so size it for DATA_W+3.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 3);
  endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// spi_bit_shifter
// Parametrised shift register with an attached down-counter. Used once for
// receive (MOSI in, parallel word out) and once for transmit (parallel word
// in, one bit per shift out).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         load load_data / load_count (has priority over shift_en)
//   load_data    parallel word to load
//   load_count   counter start value
//   shift_en     shift one position and decrement the counter
//   serial_in    bit shifted into the vacated end
//   data_next    value the register takes on the next shift
//   head_next    bit that will be at the serial head after the next shift
//   count        current counter value
module spi_bit_shifter #(
  parameter int WIDTH     = 10,
  parameter int CNT_W     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_next,
  output logic             head_next,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] data;

  // MSB-first shifts left (first bit ends at the top); LSB-first is the
  // mirror image, so the head of the serial stream is bit 0.
  always_comb begin
    data_next = (LSB_FIRST != 0) ? {serial_in, data[WIDTH-1:1]}
                                 : {data[WIDTH-2:0], serial_in};
    head_next = (LSB_FIRST != 0) ? data_next[0] : data_next[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= load_count;
    end else if (shift_en) begin
      data  <= data_next;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_slave_gen.sv
// spi_slave_gen
// SPI slave front end for the single-port RAM subsystem. Receives frames of
// a direction bit followed by DATA_W+2 payload bits ({cmd, payload}),
// presents them on rx_data with a one-cycle rx_valid pulse, and for
// read-data frames waits (bounded by TX_TIMEOUT) for tx_data and shifts it
// out on MISO.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   SS_n, MOSI   slave select (active low) and serial data from master
//   MISO         serial data to master (0 when not transmitting)
//   rx_data      last completed received word
//   rx_valid     one-cycle pulse when rx_data updates
//   tx_data      read data from RAM, taken when tx_valid is high in READ_WAIT
//   tx_valid     tx_data valid
//   frame_err    one-cycle pulse on an aborted or timed-out frame
//   busy         high whenever the FSM is not idle
module spi_slave_gen
  import spi_slave_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 0,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int RX_W  = DATA_W + 2;
  localparam int CNT_W = cnt_width(DATA_W);
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

  state_t            state;
  logic              addr_seen;
  logic [TO_W-1:0]   to_cnt;

  logic              ss_abort;
  logic              rx_load;
  logic              rx_shift;
  logic [RX_W-1:0]   rx_next;
  logic              rx_head_unused;
  logic [CNT_W-1:0]  rx_count;

  logic              tx_load;
  logic              tx_shift;
  logic              tx_first;
  logic [DATA_W-1:0] tx_next_unused;
  logic              tx_head_next;
  logic [CNT_W-1:0]  tx_count;

  assign busy = (state != IDLE);

  // SS_n rising mid-frame aborts; in IDLE and DONE it is the normal idle level.
  assign ss_abort = SS_n && (state != IDLE) && (state != DONE);

  assign rx_load  = (state == CHK_CMD);
  assign rx_shift = !SS_n &&
                    ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA));

  // The first tx bit goes straight from tx_data to MISO on the accept edge;
  // the shifter then supplies the following bits from its next value.
  assign tx_load  = (state == READ_WAIT) && !SS_n && tx_valid;
  assign tx_shift = (state == READ_TX) && !SS_n && (tx_count != '0);
  assign tx_first = (LSB_FIRST != 0) ? tx_data[0] : tx_data[DATA_W-1];

  spi_bit_shifter #(
    .WIDTH     (RX_W),
    .CNT_W     (CNT_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_rx_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (rx_load),
    .load_data  ({RX_W{1'b0}}),
    .load_count (CNT_W'(RX_W)),
    .shift_en   (rx_shift),
    .serial_in  (MOSI),
    .data_next  (rx_next),
    .head_next  (rx_head_unused),
    .count      (rx_count)
  );

  spi_bit_shifter #(
    .WIDTH     (DATA_W),
    .CNT_W     (CNT_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_load),
    .load_data  (tx_data),
    .load_count (CNT_W'(DATA_W - 1)),
    .shift_en   (tx_shift),
    .serial_in  (1'b0),
    .data_next  (tx_next_unused),
    .head_next  (tx_head_next),
    .count      (tx_count)
  );

  // Main FSM. Abort is checked before any state action so that SS_n rising
  // on the last bit wins over completion. In READ_WAIT tx_valid is tested
  // before the timeout so a response on the final wait cycle is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      addr_seen <= 1'b0;
      to_cnt    <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (ss_abort) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        MISO      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!MOSI)           state <= WRITE;
            else if (!addr_seen) state <= READ_ADD;
            else                 state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (rx_count == CNT_W'(1)) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              if (state == READ_ADD) addr_seen <= 1'b1;
              if (state == READ_DATA) begin
                state  <= READ_WAIT;
                to_cnt <= TO_W'(TX_TIMEOUT);
              end else begin
                state <= DONE;
              end
            end
          end
          READ_WAIT: begin
            if (tx_valid) begin
              MISO  <= tx_first;
              state <= READ_TX;
            end else if (to_cnt == TO_W'(1)) begin
              frame_err <= 1'b1;
              addr_seen <= 1'b0;
              state     <= DONE;
            end else begin
              to_cnt <= to_cnt - TO_W'(1);
            end
          end
          READ_TX: begin
            if (tx_count == '0) begin
              MISO      <= 1'b0;
              addr_seen <= 1'b0;
              state     <= DONE;
            end else begin
              MISO <= tx_head_next;
            end
          end
          DONE: begin
            if (SS_n) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_gen.md
# spi_slave_gen

Parametrised second-generation SPI slave front end for the single-port RAM subsystem. It deserialises MOSI frames of (DATA_W+2) payload bits into rx_data and pulses rx_valid to the RAM. For read-data frames it waits, with a timeout, for tx_data from the RAM and serialises it on MISO. Compared with the first-generation slave it adds configurable width and bit order, a single-cycle rx_valid pulse, a tx timeout and frame-abort error reporting.

## Interface
- DATA_W, 8: RAM data/address width; rx_data is DATA_W+2 bits ({cmd[1:0], payload}).
- LSB_FIRST, 0: 0 = MSB-first on both MOSI and MISO; 1 = LSB-first.
- TX_TIMEOUT, 16: maximum cycles spent in READ_WAIT before abort; must be ≥1.
- clk  in  1  single system clock; all sampling and driving on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- rx_data  out  DATA_W+2  last completed received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid; sampled only in READ_WAIT.
- frame_err  out  1  one-cycle pulse on aborted or timed-out frame.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Reset values: state IDLE, MISO 0, rx_data 0, rx_valid 0, frame_err 0, busy 0, addr_seen 0, counter 0.
- IDLE: SS_n low → CHK_CMD.
- CHK_CMD: samples MOSI as the direction bit.
  - 0 → WRITE.
  - 1 with addr_seen=0 → READ_ADD.
  - 1 with addr_seen=1 → READ_DATA.
  - In every case, load counter = DATA_W+2.
- WRITE / READ_ADD / READ_DATA (shift states): each cycle, capture MOSI into the rx shift register and decrement counter.
  - At counter→0: rx_data ← shift register and rx_valid pulses.
  - READ_ADD additionally sets addr_seen.
  - WRITE and READ_ADD then hold in DONE until SS_n rises, ignoring MOSI.
  - READ_DATA goes to READ_WAIT and loads the timeout counter = TX_TIMEOUT.
- READ_WAIT:
  - tx_valid high → latch tx_data, drive its first bit on MISO, counter = DATA_W-1, go to READ_TX.
  - Timeout expiry → frame_err pulse, clear addr_seen, go to DONE.
- READ_TX: shift out the next MISO bit each cycle. After the last bit, MISO ← 0, clear addr_seen, go to DONE.
- DONE: SS_n high → IDLE.
- SS_n high in any state other than IDLE or DONE → IDLE next cycle.
  - frame_err pulses; rx_valid does not pulse; rx_data and addr_seen are unchanged; MISO ← 0.
  - SS_n high while in CHK_CMD counts as an abort.
- Bit order: LSB_FIRST=0 fills rx from bit DATA_W+1 down to bit 0 and transmits tx from bit DATA_W-1 down. LSB_FIRST=1 is the exact mirror.
- Simultaneous events: SS_n rising in the same cycle as the last bit is an abort; the abort takes priority over completion. tx_valid and timeout expiry in the same cycle: tx_valid wins.
- Asynchronous reset mid-frame: immediate return to reset values, including addr_seen.

## Timing
- Cycle numbers below refer to posedges.
- SS_n low sampled at edge 0; direction bit sampled at edge 1; payload bits sampled at edges 2..DATA_W+3.
- rx_valid is high for exactly one cycle following edge DATA_W+3. With DATA_W=8 this is the cycle after edge 11.
- tx_valid sampled at edge t → MISO carries bit 0 of the serial order after edge t, and bit k after edge t+k. MISO returns to 0 after edge t+DATA_W.
- Timeout: with no tx_valid, frame_err pulses after edge (DATA_W+3)+TX_TIMEOUT.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package spi_slave_pkg holds:
  - state enum {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_TX, DONE};
  - command encodings WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11;
  - a counter-width function $clog2(DATA_W+3).
- Sub-module spi_bit_shifter: a parametrised shift register with down-counter and LSB_FIRST handling. Instantiate it twice, once for rx and once for tx. The FSM stays in spi_slave_gen.

## Test plan
- Write address, DATA_W=8: SS_n low; send 0, then 00_1010_0101 → one rx_valid pulse with rx_data=0x0A5; then DONE; no frame_err.
- Read address then read data: send 1, then 10_0000_0011. Then send 1, then 11_0000_0000. Drive tx_valid with tx_data=0xC3 three cycles later → MISO sequence 1,1,0,0,0,0,1,1; addr_seen cleared afterwards.
- Abort: SS_n rises after 5 payload bits of a write frame → frame_err pulse; rx_valid stays low; rx_data keeps its previous value; next cycle in IDLE.
- Timeout, TX_TIMEOUT=4: read-data frame with tx_valid never asserted → frame_err exactly 4 cycles after the rx_valid edge; MISO stays 0.
- LSB_FIRST=1, DATA_W=16: write frame carrying 0x1_2345 (LSB first) → rx_data=0x1_2345.
- Asynchronous reset asserted mid-READ_TX → MISO, rx_valid, busy and addr_seen all 0 immediately, without waiting for a clock edge.
